// File: rtl/foo_collect_pkg.sv
// Shared types and helpers for the foo edge collector.
// Build option: FOO_COLLECT_FALL_EN (falling edges also produce events).
package foo_collect_pkg;

  localparam int N_DEF = 4;

  // Lane index width; kept at least 1 so a lane index always has a bit.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LANE_W = lane_w(N_DEF);

  typedef logic [LANE_W-1:0] lane_idx_t;

  typedef struct packed {
    lane_idx_t lane;
    logic      rise;
  } evt_t;

endpackage

// File: rtl/foo_edge_collector_if.sv
// Event port of the edge collector: valid/ready handshake carrying a lane
// index and the edge polarity of the head entry.
// Build option: FOO_COLLECT_FALL_EN (rise may be 0 for falling edges).
interface foo_edge_collector_if
  import foo_collect_pkg::*;
#(
  parameter int LANE_W = foo_collect_pkg::LANE_W
);

  logic              valid;
  logic              ready;
  logic [LANE_W-1:0] lane;
  logic              rise;

  modport master (output valid, lane, rise, input ready);
  modport slave  (input valid, lane, rise, output ready);

endinterface

// File: rtl/foo_evt_fifo.sv
// Small synchronous FIFO for collected events. Head data reads zero when
// empty so the event port never shows stale entries.
// Build option: FOO_COLLECT_FALL_EN does not affect this block.
module foo_evt_fifo
  import foo_collect_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(evt_t)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every block
      // sees the pre-edge values regardless of evaluation order.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; empty entries are never
    // visible because head_data is forced to zero when the FIFO is empty.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/foo_edge_collector.sv
// Per-lane edge detector with round-robin arbitration into an event FIFO.
// Dropped events (a new edge while the same edge is still pending) are
// counted in a saturating counter and flagged by a sticky overflow bit.
// Build option: FOO_COLLECT_FALL_EN also reports falling edges (rise=0).
module foo_edge_collector
  import foo_collect_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         lane_a,
  foo_edge_collector_if.master evt,
  output logic                 overflow,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int LW = lane_w(N);
  localparam int EW = LW + 1;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef FOO_COLLECT_FALL_EN
  localparam int RQ = 2 * N;
`else
  localparam int RQ = N;
`endif
  localparam int DW = $clog2(RQ + 1);
  localparam int SW = CNT_W + DW;

  logic [N-1:0]    lane_q;
  logic [N-1:0]    rise;
  logic [N-1:0]    pend_r;
  logic [N-1:0]    grant_r;
  logic [N-1:0]    drop_r;
`ifdef FOO_COLLECT_FALL_EN
  logic [N-1:0]    fall;
  logic [N-1:0]    pend_f;
  logic [N-1:0]    grant_f;
  logic [N-1:0]    drop_f;
`endif
  logic [RQ-1:0]   drop_all;
  logic [LW-1:0]   rr_ptr;
  logic            grant_valid;
  logic [LW-1:0]   win_idx;
  logic            win_rise;
  logic            can_grant;

  logic [DW-1:0]   drop_n;
  logic [SW-1:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   unused_count;
  logic            valid;

  assign rise   = lane_a & ~lane_q;
  assign drop_r = rise & pend_r & ~grant_r;
`ifdef FOO_COLLECT_FALL_EN
  assign fall     = ~lane_a & lane_q;
  assign drop_f   = fall & pend_f & ~grant_f;
  assign drop_all = {drop_f, drop_r};
`else
  assign drop_all = drop_r;
`endif

  assign can_grant = ~fifo_full;
  assign push_data = {win_idx, win_rise};
  assign valid     = ~fifo_empty;
  assign evt.valid = valid;
  assign evt.lane  = head_data[EW-1:1];
  assign evt.rise  = head_data[0];

  // Previous lane levels; tracked through reset so lanes already high at
  // release do not produce an event.
  always_ff @(posedge clk) begin
    lane_q <= lane_a;
  end

  // Round-robin pick: first pending request scanning from rr_ptr, with a
  // lane's rise request ahead of its fall request.
  always_comb begin : arbiter
    int idx;
    // NOTE: every combinational output gets a default before the scan so no
    // path leaves it unassigned (which would infer a latch).
    grant_valid = 1'b0;
    win_idx     = '0;
    win_rise    = 1'b1;
    grant_r     = '0;
`ifdef FOO_COLLECT_FALL_EN
    grant_f     = '0;
`endif
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!grant_valid && can_grant) begin
        if (pend_r[idx]) begin
          grant_valid  = 1'b1;
          win_idx      = LW'(idx);
          win_rise     = 1'b1;
          grant_r[idx] = 1'b1;
        end
`ifdef FOO_COLLECT_FALL_EN
        else if (pend_f[idx]) begin
          grant_valid  = 1'b1;
          win_idx      = LW'(idx);
          win_rise     = 1'b0;
          grant_f[idx] = 1'b1;
        end
`endif
      end
    end
  end

  // Saturating add of this cycle's drop popcount.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < RQ; i++) begin
      drop_n = drop_n + {{(DW-1){1'b0}}, drop_all[i]};
    end
    cnt_sum  = SW'(drop_cnt) + SW'(drop_n);
    cnt_next = (cnt_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // Pending vectors, arbiter pointer and drop accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r   <= '0;
`ifdef FOO_COLLECT_FALL_EN
      pend_f   <= '0;
`endif
      rr_ptr   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      pend_r <= (pend_r & ~grant_r) | rise;
`ifdef FOO_COLLECT_FALL_EN
      pend_f <= (pend_f & ~grant_f) | fall;
`endif
      if (grant_valid) begin
        rr_ptr <= (win_idx == LW'(N - 1)) ? '0 : win_idx + LW'(1);
      end
      if (|drop_all) begin
        overflow <= 1'b1;
        drop_cnt <= cnt_next;
      end
    end
  end

  foo_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_valid),
    .push_data (push_data),
    .pop       (valid & evt.ready),
    .head_data (head_data),
    .count     (unused_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: doc/foo_edge_collector.md
Name: foo_edge_collector

Overview:
- Downstream consumer of an N-lane foo_intf array: parent drives lane_a[i] from foos[i].a (sink modport) in a generate loop.
- Detects rising edges per lane and arbitrates simultaneous events round-robin.
- Queues lane indices in a small FIFO and presents them on a valid/ready event port; counts dropped events.

Parameters:
- N, 4, number of lanes (>=2).
- DEPTH, 4, FIFO entries (power of 2, >=2).
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  sole clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- lane_a  input  N  lane i = foos[i].a.
- evt_valid  output  1  FIFO non-empty.
- evt_ready  input  1  consumer accepts the head entry.
- evt_lane  output  $clog2(N)  lane index of the head entry.
- evt_rise  output  1  edge polarity of the head entry (1 = rise).
- overflow  output  1  sticky; set on any dropped event.
- drop_cnt  output  CNT_W  saturating count of dropped events.

Behaviour:
- Reset (rst=1 at edge): pending=0, FIFO empty, rr_ptr=0, overflow=0, drop_cnt=0. lane_q<=lane_a even during reset, so lanes already high at release produce no event. Outputs after reset: evt_valid=0, evt_lane=0, evt_rise=0.
- Edge detect: rise[i] = lane_a[i] & ~lane_q[i]; lane_q<=lane_a every cycle.
- Pending: pending_next = (pending & ~grant) | rise.
- Drops: rise[i] & pending[i] & ~grant[i] → event dropped, overflow<=1, drop_cnt+=1 (saturates at 2^CNT_W-1; multiple drops in one cycle add the popcount, clamped).
- Grant and rise on the same lane in the same cycle: the grant is pushed and the new rise stays pending; this is not a drop.
- Grant: at most one per cycle, only when the registered FIFO count < DEPTH. A pop in the same cycle does not enable a push when full.
  - Winner = first set pending bit scanning rr_ptr, rr_ptr+1, … mod N.
  - On grant: push {lane, rise=1}; rr_ptr<=winner+1 mod N.
- FIFO:
  - Pop when evt_valid & evt_ready. Push and pop in the same cycle when not full: count unchanged.
  - evt_lane/evt_rise reflect mem[rd_ptr]; both read 0 when empty.
  - Pointers wrap mod DEPTH.
- Latency: lane_a first sampled high at edge k → pending after k → pushed at edge k+1 → evt_valid=1 after k+1 (2 cycles), assuming no contention.
- Throughput: 1 event/cycle sustained.
- evt_ready=0 with evt_valid=1: head entry held stable.
- Reset mid-operation discards pending and FIFO contents immediately.

Optional Feature:
- FOO_COLLECT_FALL_EN defined:
  - fall[i] = ~lane_a[i] & lane_q[i] is tracked in a second pending vector (pend_fall).
  - Arbitration order is per-lane: rise before fall within the same lane slot; each of the 2N request bits is granted in the rr_ptr scan order.
  - evt_rise=0 marks fall entries. Drops and overflow apply identically to pend_fall.
- Undefined: falls are ignored and evt_rise is a constant 1 for all entries (0 when empty).

Decomposition:
- Package foo_collect_pkg:
  - LANE_W function/localparam, lane_idx_t.
  - evt_t packed struct {lane_idx_t lane; logic rise;}.
- Sub-module foo_evt_fifo:
  - Parameters DEPTH and element type width.
  - Ports: clk, rst, push, push_data, pop, head_data, count, full, empty.
- Edge detect, pending and arbiter stay in the top module.

Test Plan:
- Single event: lane_a 0000→0100 sampled at edge 5, evt_ready=1 → evt_valid=1 for exactly one cycle after edge 6 with evt_lane=2, evt_rise=1; drop_cnt=0.
- Simultaneous: rr_ptr=0, lane_a 0000→1111, evt_ready=1 → evt_lane 0,1,2,3 on consecutive cycles; rr_ptr returns to 0.
- Fairness: after lane 1 granted (rr_ptr=2), rises on lanes 0 and 3 in the same cycle → output order 3 then 0.
- Backpressure/overflow:
  - evt_ready=0; single rises on lanes 0,1,2,3 fill the FIFO (4 entries).
  - Lane 0 then rises again → pending[0]=1.
  - Lane 0 falls and rises once more → overflow=1, drop_cnt=1.
  - Raising evt_ready then yields lanes 0,1,2,3,0 in order.
- Reset mid-operation: FIFO holding 3 entries, lane_a=1111; rst high for 1 cycle → evt_valid=0 after that edge. No events appear while lanes stay 1111; a later 1111→1110→1111 produces exactly one event, lane 0.
- With FOO_COLLECT_FALL_EN: lane 3 pulses 0→1→0 with evt_ready=1 → two events, {3,rise=1} then {3,rise=0}.
